// File: rtl/jtaglet_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtaglet_mc_if
//  Brief    : User-side bus of the jtaglet_mc TAP. It carries the per-channel
//             data shadows, the USEROP shadow and the pending/ack handshake.
//  Revision : 1.0 - initial release
// ============================================================================
interface jtaglet_mc_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_LEN   = 32,
  parameter int USEROP_LEN = 8
);
  logic [NUM_CH*DATA_LEN-1:0] userData_in;
  logic [NUM_CH*DATA_LEN-1:0] userData_out;
  logic [NUM_CH-1:0]          userData_valid;
  logic [USEROP_LEN-1:0]      userOp;
  logic                       userOp_valid;
  logic                       userOp_ack;
  logic                       userOp_pending;

  // The TAP side drives the shadows and strobes.
  modport master (
    input  userData_in, userOp_ack,
    output userData_out, userData_valid, userOp, userOp_valid, userOp_pending
  );

  // The on-chip consumer side.
  modport slave (
    output userData_in, userOp_ack,
    input  userData_out, userData_valid, userOp, userOp_valid, userOp_pending
  );
endinterface
`default_nettype wire

// File: rtl/jtaglet_mc.sv
`default_nettype none
// ============================================================================
//  Module   : jtaglet_mc
//  Brief    : Multi-channel JTAG TAP. It contains a 16-state controller, an IR,
//             BYPASS, IDCODE, USEROP with a pending/ack handshake, and NUM_CH
//             user data registers.
//  Revision : 1.0 - initial release
// ============================================================================
module jtaglet_mc #(
  parameter int          IR_LEN     = 4,
  parameter logic [3:0]  ID_PARTVER = 4'h0,
  parameter logic [15:0] ID_PARTNUM = 16'h0000,
  parameter logic [10:0] ID_MANF    = 11'h000,
  parameter int          NUM_CH     = 2,
  parameter int          DATA_LEN   = 32,
  parameter int          USEROP_LEN = 8
) (
  input  logic         tck,
  input  logic         trst,
  input  logic         tms,
  input  logic         tdi,
  output logic         tdo,
  output logic         tdo_oe,
  jtaglet_mc_if.master bus
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_t;

  typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_UOP, SEL_USR} dr_sel_t;

  localparam logic [IR_LEN-1:0] c_ir_bypass = '1;
  localparam logic [IR_LEN-1:0] c_ir_idcode = ~IR_LEN'(1);
  localparam logic [IR_LEN-1:0] c_op_ch0    = IR_LEN'(4'b1000);
  localparam logic [IR_LEN-1:0] c_op_uop    = IR_LEN'(4'b1001);
  localparam logic [IR_LEN-1:0] c_op_ch1    = IR_LEN'(4'b1010);
  localparam logic [IR_LEN-1:0] c_op_ch2    = IR_LEN'(4'b1011);
  localparam logic [IR_LEN-1:0] c_op_ch3    = IR_LEN'(4'b1100);
  localparam logic [31:0]       c_idcode    = {ID_PARTVER, ID_PARTNUM, ID_MANF, 1'b1};

  tap_state_t            r_state, w_state_nxt;
  logic [IR_LEN-1:0]     r_ir;
  logic [31:0]           r_dr_id;
  logic                  r_dr_byp;
  logic [USEROP_LEN-1:0] r_dr_uop;
  logic [DATA_LEN-1:0]   r_dr_usr;
  logic                  r_pending, r_overrun;
  logic                  r_tdo, r_tdo_oe;
  dr_sel_t               w_sel;
  logic [1:0]            w_ch;
  logic [DATA_LEN-1:0]   w_usr_cap;
  logic                  w_tdo;
  logic                  w_upd_uop, w_upd_usr;

  // TAP state register; trst forces Test-Logic-Reset.
  always_ff @(posedge tck) begin
    if (trst) r_state <= TLR;
    else      r_state <= w_state_nxt;
  end

  // IEEE 1149.1 next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TLR:     w_state_nxt = tms ? TLR    : RTI;
      RTI:     w_state_nxt = tms ? SEL_DR : RTI;
      SEL_DR:  w_state_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:  w_state_nxt = tms ? EX1_DR : SH_DR;
      SH_DR:   w_state_nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:  w_state_nxt = tms ? UPD_DR : PA_DR;
      PA_DR:   w_state_nxt = tms ? EX2_DR : PA_DR;
      EX2_DR:  w_state_nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:  w_state_nxt = tms ? SEL_DR : RTI;
      SEL_IR:  w_state_nxt = tms ? TLR    : CAP_IR;
      CAP_IR:  w_state_nxt = tms ? EX1_IR : SH_IR;
      SH_IR:   w_state_nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:  w_state_nxt = tms ? UPD_IR : PA_IR;
      PA_IR:   w_state_nxt = tms ? EX2_IR : PA_IR;
      EX2_IR:  w_state_nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:  w_state_nxt = tms ? SEL_DR : RTI;
      default: w_state_nxt = TLR;
    endcase
  end

  // Instruction decode from the live IR; unknown opcodes and absent channels fall to BYPASS.
  always_comb begin
    w_sel = SEL_BYP;
    w_ch  = 2'd0;
    if (r_ir == c_ir_idcode)                  w_sel = SEL_ID;
    else if (r_ir == c_op_uop)                w_sel = SEL_UOP;
    else if (r_ir == c_op_ch0)                w_sel = SEL_USR;
    else if (r_ir == c_op_ch1 && NUM_CH > 1) begin w_sel = SEL_USR; w_ch = 2'd1; end
    else if (r_ir == c_op_ch2 && NUM_CH > 2) begin w_sel = SEL_USR; w_ch = 2'd2; end
    else if (r_ir == c_op_ch3 && NUM_CH > 3) begin w_sel = SEL_USR; w_ch = 2'd3; end
  end

  // Capture value for the selected user channel.
  always_comb begin
    w_usr_cap = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (w_ch == 2'(k)) w_usr_cap = bus.userData_in[k*DATA_LEN +: DATA_LEN];
  end

  // IR: IDCODE in reset, status word on capture, right shift with tdi entering the MSB.
  always_ff @(posedge tck) begin
    if (trst || r_state == TLR) r_ir <= c_ir_idcode;
    else if (r_state == CAP_IR)  r_ir <= IR_LEN'({r_overrun, r_pending, 2'b01});
    else if (r_state == SH_IR)   r_ir <= {tdi, r_ir[IR_LEN-1:1]};
  end

  // DR shift registers: only the selected one captures or shifts.
  always_ff @(posedge tck) begin
    if (trst) begin
      r_dr_id  <= '0;
      r_dr_byp <= 1'b0;
      r_dr_uop <= '0;
      r_dr_usr <= '0;
    end else if (r_state == CAP_DR) begin
      case (w_sel)
        SEL_ID:  r_dr_id  <= c_idcode;
        SEL_UOP: r_dr_uop <= '0;
        SEL_USR: r_dr_usr <= w_usr_cap;
        default: r_dr_byp <= 1'b0;
      endcase
    end else if (r_state == SH_DR) begin
      case (w_sel)
        SEL_ID:  r_dr_id  <= {tdi, r_dr_id[31:1]};
        SEL_UOP: r_dr_uop <= {tdi, r_dr_uop[USEROP_LEN-1:1]};
        SEL_USR: r_dr_usr <= {tdi, r_dr_usr[DATA_LEN-1:1]};
        default: r_dr_byp <= tdi;
      endcase
    end
  end

  assign w_upd_uop = (r_state == UPD_DR) && (w_sel == SEL_UOP);
  assign w_upd_usr = (r_state == UPD_DR) && (w_sel == SEL_USR);

  // USEROP shadow, strobe and the pending/overrun handshake; an update wins over ack.
  always_ff @(posedge tck) begin
    if (trst) begin
      bus.userOp       <= '0;
      bus.userOp_valid <= 1'b0;
      r_pending        <= 1'b0;
      r_overrun        <= 1'b0;
    end else begin
      bus.userOp_valid <= w_upd_uop;
      if (w_upd_uop) bus.userOp <= r_dr_uop;
      if (r_state == TLR) begin
        r_pending <= 1'b0;
        r_overrun <= 1'b0;
      end else if (w_upd_uop) begin
        r_pending <= 1'b1;
        if (r_pending) r_overrun <= 1'b1;
      end else if (bus.userOp_ack) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign bus.userOp_pending = r_pending;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic w_hit;
      assign w_hit = w_upd_usr && (w_ch == 2'(k));
      // Channel shadow and strobe; only trst clears the shadow, TLR keeps it.
      always_ff @(posedge tck) begin
        if (trst) begin
          bus.userData_out[k*DATA_LEN +: DATA_LEN] <= '0;
          bus.userData_valid[k]                    <= 1'b0;
        end else begin
          bus.userData_valid[k] <= w_hit;
          if (w_hit) bus.userData_out[k*DATA_LEN +: DATA_LEN] <= r_dr_usr;
        end
      end
    end
  endgenerate

  // TDO source for the current shift state.
  always_comb begin
    w_tdo = 1'b0;
    if (r_state == SH_IR) w_tdo = r_ir[0];
    else if (r_state == SH_DR) begin
      case (w_sel)
        SEL_ID:  w_tdo = r_dr_id[0];
        SEL_UOP: w_tdo = r_dr_uop[0];
        SEL_USR: w_tdo = r_dr_usr[0];
        default: w_tdo = r_dr_byp;
      endcase
    end
  end

  // TDO and its enable launch on the falling edge.
  always_ff @(negedge tck) begin
    if (trst) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else begin
      r_tdo    <= w_tdo;
      r_tdo_oe <= (r_state == SH_DR) || (r_state == SH_IR);
    end
  end

  assign tdo    = r_tdo;
  assign tdo_oe = r_tdo_oe;

endmodule
`default_nettype wire
